// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared defaults and types for the multi-port register file
package regfile_mp_pkg;
  localparam int RF_XLEN = 32;
  localparam int RF_NREGS = 32;
  localparam int RF_NREAD = 2;
  localparam int RF_NWRITE = 2;
  localparam int RF_AW = $clog2(RF_NREGS);
  typedef logic [RF_XLEN-1:0] t_word;
  typedef logic [RF_AW-1:0] t_register;
  typedef enum logic {RF_IDLE, RF_CLEAR} t_rf_state;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: issue/writeback bus of the register file
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NREAD = RF_NREAD,
  parameter int NWRITE = RF_NWRITE
) ();
  localparam int AW = $clog2(NREGS);
  logic clr_req;
  logic ready;
  logic [NREAD*AW-1:0] rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0] rd_busy;
  logic [NWRITE-1:0] wr_en;
  logic [NWRITE*AW-1:0] wr_addr;
  logic [NWRITE*XLEN-1:0] wr_data;
  logic sb_set;
  logic [AW-1:0] sb_addr;
  modport master (
    output clr_req, rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    input ready, rd_data, rd_busy
  );
  modport slave (
    input clr_req, rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    output ready, rd_data, rd_busy
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// rf_scoreboard: per-register busy bits; issue set beats writeback clear, x0 never busy
module rf_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  parameter int NWRITE = RF_NWRITE,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_clr_all,
  input  logic [NWRITE-1:0]    i_wr_en,
  input  logic [NWRITE*AW-1:0] i_wr_addr,
  input  logic                 i_set,
  input  logic [AW-1:0]        i_set_addr,
  output logic [NREGS-1:0]     o_busy
);
  logic [NREGS-1:0] r_busy, w_busy_nxt;
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_en) begin
      for (int j = 0; j < NWRITE; j++)
        if (i_wr_en[j]) w_busy_nxt[i_wr_addr[j*AW +: AW]] = 1'b0;
      if (i_set) w_busy_nxt[i_set_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
    if (i_clr_all) w_busy_nxt = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_busy <= '0;
    else r_busy <= w_busy_nxt;
  assign o_busy = r_busy;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with busy scoreboard and sequential clear sweep.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data/busy clears to the read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NREAD = RF_NREAD,
  parameter int NWRITE = RF_NWRITE
) (
  input logic        clk,
  input logic        rst_n,
  regfile_mp_if.slave rf
);
  localparam int AW = $clog2(NREGS);
  t_rf_state r_state, w_state_nxt;
  logic [AW-1:0] r_ptr, w_ptr_nxt;
  logic [XLEN-1:0] r_mem [NREGS];
  logic [NREGS-1:0] w_busy;
  logic [NREAD*XLEN-1:0] w_rd_data;
  logic [NREAD-1:0] w_rd_busy;
  logic w_idle;
  assign w_idle = r_state == RF_IDLE;
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt = r_ptr;
    if (!w_idle) begin
      w_ptr_nxt = r_ptr + 1'b1;
      if (r_ptr == AW'(NREGS - 1)) w_state_nxt = RF_IDLE;
    end else if (rf.clr_req) begin
      w_state_nxt = RF_CLEAR;
      w_ptr_nxt = AW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= RF_CLEAR;
      r_ptr <= AW'(1);
    end else begin
      r_state <= w_state_nxt;
      r_ptr <= w_ptr_nxt;
    end
  // Data array has no reset; the sweep zeroes it. Later ports overwrite earlier ones.
  always_ff @(posedge clk)
    if (!w_idle) r_mem[r_ptr] <= '0;
    else
      for (int j = 0; j < NWRITE; j++)
        if (rf.wr_en[j] && rf.wr_addr[j*AW +: AW] != '0)
          r_mem[rf.wr_addr[j*AW +: AW]] <= rf.wr_data[j*XLEN +: XLEN];
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int i = 0; i < NREAD; i++)
      if (w_idle && rf.rd_addr[i*AW +: AW] != '0) begin
        w_rd_data[i*XLEN +: XLEN] = r_mem[rf.rd_addr[i*AW +: AW]];
        w_rd_busy[i] = w_busy[rf.rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWRITE; j++)
          if (rf.wr_en[j] && rf.wr_addr[j*AW +: AW] == rf.rd_addr[i*AW +: AW]) begin
            w_rd_data[i*XLEN +: XLEN] = rf.wr_data[j*XLEN +: XLEN];
            w_rd_busy[i] = w_busy[rf.rd_addr[i*AW +: AW]] & rf.sb_set
                           & (rf.sb_addr == rf.rd_addr[i*AW +: AW]);
          end
`endif
      end
  end
  assign rf.rd_data = w_rd_data;
  assign rf.rd_busy = w_rd_busy;
  assign rf.ready = w_idle;
  rf_scoreboard #(.NREGS(NREGS), .NWRITE(NWRITE)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .i_en(w_idle),
    .i_clr_all(w_idle && rf.clr_req),
    .i_wr_en(rf.wr_en),
    .i_wr_addr(rf.wr_addr),
    .i_set(rf.sb_set),
    .i_set_addr(rf.sb_addr),
    .o_busy(w_busy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: queue-scoreboard bench for regfile_mp (honours REGFILE_BYPASS_EN)
module tb_regfile_mp;
  import regfile_mp_pkg::*;
  localparam int XLEN = 32, NREGS = 32, NREAD = 2, NWRITE = 2, AW = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)) rf ();
  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rf(rf)
  );
  int total = 0;
  int bad = 0;
  logic [31:0] q_exp[$];
  logic [31:0] exp_v;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    rf.clr_req = 1'b0;
    rf.wr_en = '0;
    rf.sb_set = 1'b0;
  endtask
  task automatic rd(input int p, input t_register a);
    rf.rd_addr[p*AW +: AW] = a;
    #1;
  endtask
  task automatic wr(input int p, input t_register a, input logic [31:0] d);
    rf.wr_en[p] = 1'b1;
    rf.wr_addr[p*AW +: AW] = a;
    rf.wr_data[p*XLEN +: XLEN] = d;
  endtask
  task automatic test_reset();
    int n;
    idle_in();
    rf.rd_addr = '0;
    rf.wr_addr = '0;
    rf.wr_data = '0;
    rf.sb_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    q_exp.push_back(32'd0);
    exp_v = q_exp.pop_front();
    total++;
    if ({31'd0, rf.ready} !== exp_v) begin
      bad++;
      $display("FAIL reset_ready got=%0d want=%0d", rf.ready, exp_v);
    end
    rst_n = 1'b1;
    n = 0;
    q_exp.push_back(32'd31);
    while (rf.ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    exp_v = q_exp.pop_front();
    total++;
    if (32'(n) !== exp_v) begin
      bad++;
      $display("FAIL sweep_len got=%0d want=%0d", n, exp_v);
    end
    for (int r = 1; r < NREGS; r++) begin
      q_exp.push_back(32'd0);
      rd(0, t_register'(r));
      exp_v = q_exp.pop_front();
      total++;
      if (rf.rd_data[31:0] !== exp_v || rf.rd_busy[0] !== 1'b0) begin
        bad++;
        $display("FAIL reset_x%0d got=%h/%b want=%h/0", r, rf.rd_data[31:0], rf.rd_busy[0], exp_v);
      end
    end
  endtask
  task automatic test_write_priority();
    wr(0, 5'd5, 32'hDEAD_BEEF);
    wr(1, 5'd5, 32'h1234_5678);
    q_exp.push_back(32'h1234_5678);
    tick();
    idle_in();
    rd(0, 5'd5);
    exp_v = q_exp.pop_front();
    total++;
    if (rf.rd_data[31:0] !== exp_v) begin
      bad++;
      $display("FAIL wr_prio got=%h want=%h", rf.rd_data[31:0], exp_v);
    end
    wr(0, 5'd10, 32'hAAAA_0001);
    wr(1, 5'd11, 32'hBBBB_0002);
    q_exp.push_back(32'hAAAA_0001);
    q_exp.push_back(32'hBBBB_0002);
    tick();
    idle_in();
    rd(1, 5'd10);
    exp_v = q_exp.pop_front();
    total++;
    if (rf.rd_data[63:32] !== exp_v) begin
      bad++;
      $display("FAIL wr_dual_x10 got=%h want=%h", rf.rd_data[63:32], exp_v);
    end
    rd(0, 5'd11);
    exp_v = q_exp.pop_front();
    total++;
    if (rf.rd_data[31:0] !== exp_v) begin
      bad++;
      $display("FAIL wr_dual_x11 got=%h want=%h", rf.rd_data[31:0], exp_v);
    end
  endtask
  task automatic test_x0();
    wr(0, 5'd0, 32'hFFFF_FFFF);
    rf.sb_set = 1'b1;
    rf.sb_addr = 5'd0;
    q_exp.push_back(32'd0);
    tick();
    idle_in();
    rd(0, 5'd0);
    exp_v = q_exp.pop_front();
    total++;
    if (rf.rd_data[31:0] !== exp_v || rf.rd_busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL x0 got=%h/%b want=%h/0", rf.rd_data[31:0], rf.rd_busy[0], exp_v);
    end
  endtask
  task automatic test_busy();
    rf.sb_set = 1'b1;
    rf.sb_addr = 5'd7;
    q_exp.push_back(32'd1);
    q_exp.push_back(32'd0);
    tick();
    idle_in();
    rd(0, 5'd7);
    rd(1, 5'd8);
    exp_v = q_exp.pop_front();
    total++;
    if ({31'd0, rf.rd_busy[0]} !== exp_v) begin
      bad++;
      $display("FAIL busy_set got=%b want=%0d", rf.rd_busy[0], exp_v);
    end
    exp_v = q_exp.pop_front();
    total++;
    if ({31'd0, rf.rd_busy[1]} !== exp_v) begin
      bad++;
      $display("FAIL busy_other got=%b want=%0d", rf.rd_busy[1], exp_v);
    end
    wr(0, 5'd7, 32'h0000_0001);
    rf.sb_set = 1'b1;
    rf.sb_addr = 5'd7;
    q_exp.push_back(32'd1);
    tick();
    idle_in();
    exp_v = q_exp.pop_front();
    total++;
    if ({31'd0, rf.rd_busy[0]} !== exp_v) begin
      bad++;
      $display("FAIL busy_set_wins got=%b want=%0d", rf.rd_busy[0], exp_v);
    end
    wr(1, 5'd7, 32'h0000_0002);
    q_exp.push_back(32'd0);
    q_exp.push_back(32'h0000_0002);
    tick();
    idle_in();
    exp_v = q_exp.pop_front();
    total++;
    if ({31'd0, rf.rd_busy[0]} !== exp_v) begin
      bad++;
      $display("FAIL busy_clear got=%b want=%0d", rf.rd_busy[0], exp_v);
    end
    exp_v = q_exp.pop_front();
    total++;
    if (rf.rd_data[31:0] !== exp_v) begin
      bad++;
      $display("FAIL x7_data got=%h want=%h", rf.rd_data[31:0], exp_v);
    end
  endtask
  task automatic test_bypass();
    wr(0, 5'd3, 32'h1111_1111);
    tick();
    idle_in();
    wr(1, 5'd3, 32'hA5A5_A5A5);
`ifdef REGFILE_BYPASS_EN
    q_exp.push_back(32'hA5A5_A5A5);
`else
    q_exp.push_back(32'h1111_1111);
`endif
    q_exp.push_back(32'hA5A5_A5A5);
    rd(0, 5'd3);
    exp_v = q_exp.pop_front();
    total++;
    if (rf.rd_data[31:0] !== exp_v) begin
      bad++;
      $display("FAIL bypass_same got=%h want=%h", rf.rd_data[31:0], exp_v);
    end
    tick();
    idle_in();
    exp_v = q_exp.pop_front();
    total++;
    if (rf.rd_data[31:0] !== exp_v) begin
      bad++;
      $display("FAIL bypass_after got=%h want=%h", rf.rd_data[31:0], exp_v);
    end
  endtask
  task automatic test_clear_reset();
    int n;
    wr(0, 5'd9, 32'h0000_0055);
    rf.sb_set = 1'b1;
    rf.sb_addr = 5'd12;
    q_exp.push_back(32'h0000_0055);
    q_exp.push_back(32'd1);
    tick();
    idle_in();
    rd(0, 5'd9);
    rd(1, 5'd12);
    exp_v = q_exp.pop_front();
    total++;
    if (rf.rd_data[31:0] !== exp_v) begin
      bad++;
      $display("FAIL x9_pre got=%h want=%h", rf.rd_data[31:0], exp_v);
    end
    exp_v = q_exp.pop_front();
    total++;
    if ({31'd0, rf.rd_busy[1]} !== exp_v) begin
      bad++;
      $display("FAIL x12_busy_pre got=%b want=%0d", rf.rd_busy[1], exp_v);
    end
    rf.clr_req = 1'b1;
    q_exp.push_back(32'd0);
    q_exp.push_back(32'd0);
    tick();
    idle_in();
    #1;
    exp_v = q_exp.pop_front();
    total++;
    if ({31'd0, rf.ready} !== exp_v) begin
      bad++;
      $display("FAIL clr_ready got=%b want=%0d", rf.ready, exp_v);
    end
    exp_v = q_exp.pop_front();
    total++;
    if (rf.rd_data[31:0] !== exp_v || rf.rd_busy[1] !== 1'b0) begin
      bad++;
      $display("FAIL clr_read got=%h/%b want=%h/0", rf.rd_data[31:0], rf.rd_busy[1], exp_v);
    end
    repeat (8) tick();
    rst_n = 1'b0;
    q_exp.push_back(32'd0);
    #2;
    exp_v = q_exp.pop_front();
    total++;
    if ({31'd0, rf.ready} !== exp_v) begin
      bad++;
      $display("FAIL midreset_ready got=%b want=%0d", rf.ready, exp_v);
    end
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    q_exp.push_back(32'd31);
    while (rf.ready !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (n == 20) wr(0, 5'd2, 32'hDEAD_0002);
      else idle_in();
    end
    idle_in();
    exp_v = q_exp.pop_front();
    total++;
    if (32'(n) !== exp_v) begin
      bad++;
      $display("FAIL resweep_len got=%0d want=%0d", n, exp_v);
    end
    q_exp.push_back(32'd0);
    q_exp.push_back(32'd0);
    q_exp.push_back(32'd0);
    rd(0, 5'd9);
    rd(1, 5'd12);
    exp_v = q_exp.pop_front();
    total++;
    if (rf.rd_data[31:0] !== exp_v || rf.rd_busy[1] !== 1'b0) begin
      bad++;
      $display("FAIL x9_post got=%h/%b want=%h/0", rf.rd_data[31:0], rf.rd_busy[1], exp_v);
    end
    rd(0, 5'd2);
    exp_v = q_exp.pop_front();
    total++;
    if (rf.rd_data[31:0] !== exp_v) begin
      bad++;
      $display("FAIL wr_in_clear got=%h want=%h", rf.rd_data[31:0], exp_v);
    end
    rd(1, 5'd5);
    exp_v = q_exp.pop_front();
    total++;
    if (rf.rd_data[63:32] !== exp_v) begin
      bad++;
      $display("FAIL x5_post got=%h want=%h", rf.rd_data[63:32], exp_v);
    end
  endtask
  initial begin
    test_reset();
    test_write_priority();
    test_x0();
    test_busy();
    test_bypass();
    test_clear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
